// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// hazard_scoreboard_pkg -- shared constants for the issue hazard scoreboard.
// Build option: HAZARD_FORWARD_EN selects forwarding instead of full stalling.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

  localparam int DEFAULT_ADDR_W = 6;
  // Registers below this index are hardwired constants and never create hazards.
  localparam int SPECIAL_REGS   = 4;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ALU   = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STORE = 3'd3,
    OP_JUMP  = 3'd4
  } opcode_e;

`ifdef HAZARD_FORWARD_EN
  localparam bit FORWARD_EN = 1'b1;
`else
  localparam bit FORWARD_EN = 1'b0;
`endif

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_match.sv
// ============================================================================
// hazard_match -- compares one operand against all in-flight writers and
// reports the youngest match plus the resulting stall request.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int  ADDR_W = DEFAULT_ADDR_W,
  parameter int  STAGES = 3,
  localparam int SW     = $clog2(STAGES + 1)
) (
  input  logic [STAGES-1:0]        entry_valid,
  input  logic [STAGES*ADDR_W-1:0] entry_dst,
  input  logic [STAGES-1:0]        entry_ld,
  input  logic                     addr_used,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     stall_req,
  output logic [SW-1:0]            fwd_stage
);

  logic              not_const;
  logic [STAGES-1:0] match;
  logic              hit;
  logic [SW-1:0]     hit_stage;
  logic              hit_ld;
  logic              ld_block;

  assign not_const = (addr >= ADDR_W'(SPECIAL_REGS));

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign match[k] = entry_valid[k] & addr_used & not_const &
                      (entry_dst[k*ADDR_W +: ADDR_W] == addr);
  end

  // Scan oldest to youngest so the lowest stage number wins.
  always_comb begin
    hit       = 1'b0;
    hit_stage = '0;
    hit_ld    = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit       = 1'b1;
        hit_stage = SW'(k + 1);
        hit_ld    = entry_ld[k];
      end
    end
  end

  assign ld_block  = hit & (hit_stage == SW'(1)) & hit_ld;
  assign stall_req = FORWARD_EN ? ld_block : hit;
  assign fwd_stage = FORWARD_EN ? hit_stage : '0;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard -- in-flight writer tracker producing issue stall and
// operand forwarding selects. Build option: HAZARD_FORWARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int  ADDR_W = DEFAULT_ADDR_W,
  parameter int  STAGES = 3,
  parameter int  CNT_W  = 16,
  localparam int SW     = $clog2(STAGES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_s,
  input  logic [ADDR_W-1:0] issue_d,
  input  logic              issue_s_used,
  input  logic              issue_d_used,
  input  logic              issue_wr,
  input  logic              issue_ld,
  input  logic              flush,
  output logic              stall,
  output logic [SW-1:0]     fwd_s,
  output logic [SW-1:0]     fwd_d,
  output logic [SW-1:0]     occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  // Bit k-1 of each vector holds the entry issued k cycles ago.
  logic [STAGES-1:0]        valid_q, valid_d;
  logic [STAGES-1:0]        ld_q, ld_d;
  logic [STAGES*ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]         stall_count_q, stall_count_d;

  logic stall_req_s, stall_req_d;
  logic accept;

  hazard_match #(
    .ADDR_W (ADDR_W),
    .STAGES (STAGES)
  ) u_match_s (
    .entry_valid (valid_q),
    .entry_dst   (dst_q),
    .entry_ld    (ld_q),
    .addr_used   (issue_s_used),
    .addr        (issue_s),
    .stall_req   (stall_req_s),
    .fwd_stage   (fwd_s)
  );

  hazard_match #(
    .ADDR_W (ADDR_W),
    .STAGES (STAGES)
  ) u_match_d (
    .entry_valid (valid_q),
    .entry_dst   (dst_q),
    .entry_ld    (ld_q),
    .addr_used   (issue_d_used),
    .addr        (issue_d),
    .stall_req   (stall_req_d),
    .fwd_stage   (fwd_d)
  );

  assign stall  = issue_valid & ~flush & (stall_req_s | stall_req_d);
  assign accept = issue_valid & ~flush & ~stall;

  always_comb begin
    valid_d = {valid_q[STAGES-2:0], accept & issue_wr};
    ld_d    = {ld_q[STAGES-2:0], issue_ld};
    dst_d   = {dst_q[(STAGES-1)*ADDR_W-1:0], issue_d};
    if (flush) begin
      valid_d = '0;
    end
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + SW'(valid_q[k]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      ld_q          <= '0;
      dst_q         <= '0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      ld_q          <= ld_d;
      dst_q         <= dst_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard -- directed checks of the hazard scoreboard in the
// configured HAZARD_FORWARD_EN mode, plus a 4-bit counter saturation build.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int NS = FWD ? 1 : 3;

  logic       clock;
  logic       reset;
  logic       issue_valid, issue_s_used, issue_d_used, issue_wr, issue_ld, flush;
  logic [5:0] issue_s, issue_d;
  logic       stall;
  logic [1:0] fwd_s, fwd_d, occupancy;
  logic [15:0] stall_count;

  logic       v4, su4, du4, wr4, ld4;
  logic [5:0] s4, d4;
  logic       stall4;
  logic [1:0] fwd_s4, fwd_d4, occ4;
  logic [3:0] cnt4;

  int tests;
  int failed;

  hazard_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_s      (issue_s),
    .issue_d      (issue_d),
    .issue_s_used (issue_s_used),
    .issue_d_used (issue_d_used),
    .issue_wr     (issue_wr),
    .issue_ld     (issue_ld),
    .flush        (flush),
    .stall        (stall),
    .fwd_s        (fwd_s),
    .fwd_d        (fwd_d),
    .occupancy    (occupancy),
    .stall_count  (stall_count)
  );

  hazard_scoreboard #(.CNT_W(4)) dut4 (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (v4),
    .issue_s      (s4),
    .issue_d      (d4),
    .issue_s_used (su4),
    .issue_d_used (du4),
    .issue_wr     (wr4),
    .issue_ld     (ld4),
    .flush        (1'b0),
    .stall        (stall4),
    .fwd_s        (fwd_s4),
    .fwd_d        (fwd_d4),
    .occupancy    (occ4),
    .stall_count  (cnt4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [5:0] s, input logic [5:0] d,
                           input logic su, input logic du, input logic wr, input logic ld);
    issue_valid  = v;
    issue_s      = s;
    issue_d      = d;
    issue_s_used = su;
    issue_d_used = du;
    issue_wr     = wr;
    issue_ld     = ld;
  endtask

  task automatic set4(input logic v, input logic [5:0] s, input logic [5:0] d,
                      input logic su, input logic du, input logic wr, input logic ld);
    v4 = v; s4 = s; d4 = d; su4 = su; du4 = du; wr4 = wr; ld4 = ld;
  endtask

  task automatic round4();
    set4(1'b1, 6'd0, 6'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    set4(1'b1, 6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (NS) tick();
    tick();
    set4(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    flush  = 1'b0;
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set4(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, with an issue presented while held in reset.
    #12;
    set_issue(1'b1, 6'd5, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_s", fwd_s, 0);
    chk("rst_fwd_d", fwd_d, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_cnt", stall_count, 0);
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Add to r5, then read r5 next cycle.
    set_issue(1'b1, 6'd0, 6'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("a_issue_stall", stall, 0);
    tick();
    set_issue(1'b1, 6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef HAZARD_FORWARD_EN
    chk("a_fwd_stall", stall, 0);
    chk("a_fwd_s", fwd_s, 1);
    chk("a_fwd_occ", occupancy, 1);
    tick();
`else
    for (int i = 0; i < 3; i++) begin
      chk("a_stall", stall, 1);
      chk("a_fwd_s_tied", fwd_s, 0);
      tick();
    end
    chk("a_accept", stall, 0);
    chk("a_cnt", stall_count, 3);
    tick();
`endif
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("a_drain_occ", occupancy, 0);

    // Load to r9, then use r9 as the d operand.
    set_issue(1'b1, 6'd0, 6'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 6'd0, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef HAZARD_FORWARD_EN
    chk("b_ld_stall", stall, 1);
    tick();
    chk("b_after_stall", stall, 0);
    chk("b_fwd_d", fwd_d, 2);
    chk("b_cnt", stall_count, 1);
    tick();
`else
    for (int i = 0; i < 3; i++) begin
      chk("b_stall", stall, 1);
      tick();
    end
    chk("b_accept", stall, 0);
    chk("b_fwd_d_tied", fwd_d, 0);
    chk("b_cnt", stall_count, 6);
    tick();
`endif
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Constant register r2 never hazards; r4 is the first real register.
    set_issue(1'b1, 6'd0, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 6'd2, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("c_const_stall", stall, 0);
    chk("c_const_fwd", fwd_s, 0);
    tick();
    set_issue(1'b1, 6'd0, 6'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 6'd4, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("c_unused_stall", stall, 0);
    set_issue(1'b1, 6'd4, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("c_r4_stall", stall, FWD ? 0 : 1);
    chk("c_r4_fwd", fwd_s, FWD ? 1 : 0);
    chk("c_occ", occupancy, 2);
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Back-to-back writers to r7, issue-with-retire, youngest match, flush.
    for (int i = 0; i < 3; i++) begin
      set_issue(1'b1, 6'd0, 6'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("d_occ3", occupancy, 3);
    tick();
    chk("d_occ_retire", occupancy, 3);
    set_issue(1'b1, 6'd7, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("d_read_stall", stall, FWD ? 0 : 1);
    chk("d_youngest", fwd_s, FWD ? 1 : 0);
    flush = 1'b1;
    #1;
    chk("d_flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("d_flush_occ", occupancy, 0);
    chk("d_post_stall", stall, 0);
    chk("d_post_fwd", fwd_s, 0);
    chk("d_cnt_kept", stall_count, FWD ? 1 : 6);
    tick();
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Reset asserted mid-operation, then a normal issue right after release.
    set_issue(1'b1, 6'd0, 6'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("e_rst_occ", occupancy, 0);
    chk("e_rst_cnt", stall_count, 0);
    set_issue(1'b1, 6'd8, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("e_rst_stall", stall, 0);
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    set_issue(1'b1, 6'd0, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("e_first_occ", occupancy, 1);
    set_issue(1'b1, 6'd10, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("e_first_stall", stall, FWD ? 0 : 1);
    chk("e_first_fwd", fwd_s, FWD ? 1 : 0);
    set_issue(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation of a 4-bit stall counter.
    repeat (4) round4();
    chk("f_cnt_partial", cnt4, 4 * NS);
    repeat (FWD ? 16 : 3) round4();
    chk("f_cnt_sat", cnt4, 15);
    round4();
    chk("f_cnt_held", cnt4, 15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning register-address width.
REQ-002 SHALL have parameter STAGES, default 3, meaning the number of in-flight stages tracked after issue (2..8).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-004 SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port issue_valid, input, 1 bit: an instruction is presented for issue.
REQ-007 SHALL have ports issue_s and issue_d, input, ADDR_W each: the source and destination register addresses.
REQ-008 SHALL have ports issue_s_used and issue_d_used, input, 1 bit each: the instruction reads s, and reads d, respectively.
REQ-009 SHALL have port issue_wr, input, 1 bit: the instruction writes register d.
REQ-010 SHALL have port issue_ld, input, 1 bit: the instruction is a load, with its result available no earlier than stage 2.
REQ-011 SHALL have port flush, input, 1 bit: a taken jump; kill all in-flight entries.
REQ-012 SHALL have port stall, output, 1 bit: the issue is refused this cycle.
REQ-013 SHALL have ports fwd_s and fwd_d, output, clog2(STAGES+1) each: the forwarding source stage, where 0 means read the register file.
REQ-014 SHALL have port occupancy, output, clog2(STAGES+1): the count of valid in-flight writers.
REQ-015 SHALL have port stall_count, output, CNT_W: the number of stalled cycles, saturating.

Function
REQ-016 SHALL hold STAGES entries {valid, dst, ld}; entry k holds the instruction issued k cycles earlier.
REQ-017 SHALL shift entry k to k+1 on every clock edge; entry STAGES retires (writeback) and is dropped.
REQ-018 SHALL load entry 1, on an edge with issue_valid=1, stall=0 and flush=0, with {issue_wr, issue_d, issue_ld}; otherwise entry 1 SHALL become invalid (bubble).
REQ-019 SHALL define "match on s at stage k" as: entry k valid, issue_s_used=1, dst==issue_s, and issue_s>=4; the same rule applies for d. Registers 0..3 are constants and never hazard.
REQ-020 SHALL compute stall, fwd_s, fwd_d and occupancy combinationally from current entries and inputs, with no added latency.
REQ-021 SHALL force stall=0 when issue_valid=0 or flush=1.
REQ-022 SHALL resolve multiple matching stages by reporting the youngest, i.e. the lowest k.
REQ-023 SHALL increment stall_count on each edge where stall=1, saturating at all-ones with no wrap.
REQ-024 SHALL invalidate all entries on the same edge when flush=1; the issue on that cycle is discarded, and occupancy reads 0 on the following cycle.
REQ-025 SHALL let the stage-STAGES entry shift out unaffected when issue and retirement occur on the same edge.

Reset
REQ-026 SHALL, while reset=0, immediately clear all entries to invalid, set stall_count=0 and occupancy=0, and set stall=0 and fwd_s=fwd_d=0.
REQ-027 SHALL discard any in-flight entries on reset assertion mid-operation; after release, the first edge SHALL accept a normal issue.

Configuration
REQ-028 SHALL support macro HAZARD_FORWARD_EN.
REQ-029 SHALL, when HAZARD_FORWARD_EN is defined, stall only on a match at stage 1 whose entry has ld=1; every other match SHALL be reported on fwd_s/fwd_d with stall=0.
REQ-030 SHALL, when HAZARD_FORWARD_EN is undefined, stall on any match at any stage, and SHALL tie fwd_s and fwd_d to 0.

Structure
REQ-031 SHALL place shared package constants in the package: opcode encodings, the special-register count (4), and the default ADDR_W.
REQ-032 SHALL implement the per-operand match-and-priority logic as one sub-module, hazard_match, instantiated once for s and once for d.

Verification
REQ-033 SHALL verify: reset low, then issue add d=5, then next cycle read s=5 with forwarding undefined -> stall=1 for 3 cycles, stall_count=3, accepted on the 4th.
REQ-034 SHALL verify: the same sequence with HAZARD_FORWARD_EN defined -> stall=0 and fwd_s=1 on the next cycle.
REQ-035 SHALL verify: ld d=9, then next cycle use d=9 with forwarding defined -> stall=1 for one cycle, then fwd_d=2.
REQ-036 SHALL verify: issue writes to d=2, then read s=2 -> no stall, fwd_s=0 (constant register).
REQ-037 SHALL verify: 3 back-to-back writers to d=7, then flush=1 -> occupancy=0 next cycle, and a following read of 7 gives stall=0.
REQ-038 SHALL verify: stall_count preloaded near saturation via a CNT_W=4 build with 20 stall cycles -> stall_count=15 and held.
